// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style slave responder over an internal 32-bit word-addressed SRAM.
// FIXED/INCR bursts up to 16 beats, one outstanding transaction per channel.
module axi_sram_slave #(
    parameter int         MEM_WORDS   = 4096,
    parameter int         IDX_WIDTH   = $clog2(MEM_WORDS),
    parameter logic [1:0] RESP_SLVERR = 2'b10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem [MEM_WORDS];
    r_state_e    r_state_q;
    w_state_e    w_state_q;
    logic [31:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
    logic [3:0]  r_cnt_q, w_cnt_q;
    logic [2:0]  r_size_q, w_size_q;
    logic [1:0]  r_burst_q, w_burst_q;
    logic        w_err_q, w_err_d;
    logic        unused_ok;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s,
                                              input logic [1:0] b);
        return (b == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    assign r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q);
    assign w_addr_d  = next_addr(w_addr_q, w_size_q, w_burst_q);
    // A wlast that disagrees with our own beat count marks the burst as erroneous.
    assign w_err_d   = w_err_q | (wlast != (w_cnt_q == 4'd0));
    assign unused_ok = ^{wid, arlen[7:4], awlen[7:4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready   <= 1'b1;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rid       <= 4'd0;
            rresp     <= 2'b00;
            rdata     <= 32'd0;
        end else begin
            case (r_state_q)
                R_IDLE: if (arvalid && arready) begin
                    rid       <= arid;
                    r_cnt_q   <= arlen[3:0];
                    r_size_q  <= arsize;
                    r_burst_q <= arburst;
                    r_addr_q  <= araddr;
                    rdata     <= mem[araddr[IDX_WIDTH+1:2]];
                    rresp     <= arburst[1] ? RESP_SLVERR : 2'b00;
                    rlast     <= (arlen[3:0] == 4'd0);
                    rvalid    <= 1'b1;
                    arready   <= 1'b0;
                    r_state_q <= R_DATA;
                end
                default: if (rready) begin
                    if (rlast) begin
                        rvalid    <= 1'b0;
                        rlast     <= 1'b0;
                        arready   <= 1'b1;
                        r_state_q <= R_IDLE;
                    end else begin
                        r_cnt_q  <= r_cnt_q - 4'd1;
                        r_addr_q <= r_addr_d;
                        rdata    <= mem[r_addr_d[IDX_WIDTH+1:2]];
                        rlast    <= (r_cnt_q == 4'd1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= 4'd0;
            bresp     <= 2'b00;
        end else begin
            case (w_state_q)
                W_IDLE: if (awvalid && awready) begin
                    bid       <= awid;
                    w_cnt_q   <= awlen[3:0];
                    w_size_q  <= awsize;
                    w_burst_q <= awburst;
                    w_addr_q  <= awaddr;
                    w_err_q   <= awburst[1];
                    awready   <= 1'b0;
                    wready    <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (wvalid) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mem[w_addr_q[IDX_WIDTH+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                    w_err_q  <= w_err_d;
                    w_addr_q <= w_addr_d;
                    w_cnt_q  <= w_cnt_q - 4'd1;
                    if (w_cnt_q == 4'd0) begin
                        wready    <= 1'b0;
                        bvalid    <= 1'b1;
                        bresp     <= w_err_d ? RESP_SLVERR : 2'b00;
                        w_state_q <= W_RESP;
                    end
                end
                default: if (bready) begin
                    bvalid    <= 1'b0;
                    awready   <= 1'b1;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed scenario tests for axi_sram_slave, driven and sampled on negedge.
module tb_axi_sram_slave;
    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  arid = '0, rid, awid = '0, wid = '0, bid;
    logic [31:0] araddr = '0, rdata, awaddr = '0, wdata = '0;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = '0, awsize = '0;
    logic [1:0]  arburst = '0, rresp, awburst = '0, bresp;
    logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0;
    logic [3:0]  wstrb = '0;

    int n_chk = 0, n_fail = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic [3:0]  rids;

    axi_sram_slave dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic timeout(input string what);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting, required handshake within 50 cycles", what);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int last_beat,
                            output logic [1:0] resp, output logic [3:0] resp_id);
        int t;
        @(negedge clk);
        awaddr = addr; awlen = {4'd0, len}; awsize = 3'd2; awburst = burst; awid = id; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("aw");
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_beat); wvalid = 1'b1; wid = id;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("w");
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("b");
        resp = bresp; resp_id = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int t;
        @(negedge clk);
        araddr = addr; arlen = {4'd0, len}; arsize = 3'd2; arburst = burst; arid = id; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("ar");
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!rvalid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("r");
            rd[i] = rdata; rr[i] = rresp; rl[i] = rlast; rids = rid;
            @(negedge clk);
        end
        rready = 1'b0;
    endtask

    task automatic test_reset;
        n_chk++;
        if ({arready, awready} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready: got %b required 11", {arready, awready});
        end
        n_chk++;
        if ({rvalid, rlast, wready, bvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_valids: got %b required 0000", {rvalid, rlast, wready, bvalid});
        end
        n_chk++;
        if ({rid, bid, rresp, bresp, rdata} !== 44'd0) begin
            n_fail++; $display("FAIL reset_fields: got rid=%h bid=%h rresp=%b bresp=%b rdata=%h required zeros",
                               rid, bid, rresp, bresp, rdata);
        end
    endtask

    task automatic test_single;
        logic [1:0] resp; logic [3:0] b_id;
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(32'h40, 4'd0, 2'b01, 4'd5, 0, resp, b_id);
        n_chk++;
        if (resp !== 2'b00 || b_id !== 4'd5) begin
            n_fail++; $display("FAIL single_b: got bresp=%b bid=%h required 00/5", resp, b_id);
        end
        do_read(32'h40, 4'd0, 2'b01, 4'd3);
        n_chk++;
        if (rd[0] !== 32'hDEADBEEF || rl[0] !== 1'b1 || rr[0] !== 2'b00 || rids !== 4'd3) begin
            n_fail++; $display("FAIL single_r: got data=%h last=%b resp=%b id=%h required deadbeef/1/00/3",
                               rd[0], rl[0], rr[0], rids);
        end
        n_chk++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++; $display("FAIL single_end: got rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
    endtask

    task automatic test_incr_read;
        logic [1:0] resp; logic [3:0] b_id;
        int k, cyc;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(32'h80, 4'd3, 2'b01, 4'd1, 3, resp, b_id);
        @(negedge clk);
        araddr = 32'h80; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arid = 4'd7; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 20) begin
            n_chk++;
            if (rvalid !== 1'b1 || rdata !== 32'(k + 1) || rlast !== (k == 3)) begin
                n_fail++; $display("FAIL incr_beat%0d: got valid=%b data=%h last=%b required 1/%h/%b",
                                   k, rvalid, rdata, rlast, k + 1, k == 3);
            end
            rready = cyc[0];
            if (rready) k++;
            cyc++;
            @(negedge clk);
        end
        rready = 1'b0;
        n_chk++;
        if (k !== 4 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL incr_end: got beats=%0d rvalid=%b required 4/0", k, rvalid);
        end
    endtask

    task automatic test_fixed_write;
        logic [1:0] resp; logic [3:0] b_id;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h11110000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h100, 4'd3, 2'b01, 4'd2, 3, resp, b_id);
        for (int i = 0; i < 4; i++) wd[i] = 32'hA + 32'(i);
        do_write(32'h100, 4'd3, 2'b00, 4'd4, 3, resp, b_id);
        n_chk++;
        if (resp !== 2'b00) begin
            n_fail++; $display("FAIL fixed_bresp: got %b required 00", resp);
        end
        do_read(32'h100, 4'd3, 2'b01, 4'd0);
        n_chk++;
        if (rd[0] !== 32'hD || rd[1] !== 32'h11110001 || rd[2] !== 32'h11110002 || rd[3] !== 32'h11110003) begin
            n_fail++; $display("FAIL fixed_mem: got %h %h %h %h required d 11110001 11110002 11110003",
                               rd[0], rd[1], rd[2], rd[3]);
        end
    endtask

    task automatic test_strobe;
        logic [1:0] resp; logic [3:0] b_id;
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(32'h140, 4'd0, 2'b01, 4'd0, 0, resp, b_id);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(32'h140, 4'd0, 2'b01, 4'd0, 0, resp, b_id);
        do_read(32'h140, 4'd0, 2'b01, 4'd0);
        n_chk++;
        if (rd[0] !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL strobe: got %h required 11bb33dd", rd[0]);
        end
    endtask

    task automatic test_errors;
        logic [1:0] resp; logic [3:0] b_id;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5000 + 32'(i); ws[i] = 4'hF; end
        do_write(32'h200, 4'd3, 2'b01, 4'd6, 1, resp, b_id);
        n_chk++;
        if (resp !== 2'b10 || b_id !== 4'd6) begin
            n_fail++; $display("FAIL early_wlast_bresp: got %b/%h required 10/6", resp, b_id);
        end
        do_read(32'h200, 4'd3, 2'b01, 4'd0);
        n_chk++;
        if (rd[0] !== 32'h5000 || rd[1] !== 32'h5001 || rd[2] !== 32'h5002 || rd[3] !== 32'h5003) begin
            n_fail++; $display("FAIL early_wlast_mem: got %h %h %h %h required 5000..5003",
                               rd[0], rd[1], rd[2], rd[3]);
        end
        do_read(32'h200, 4'd1, 2'b11, 4'd8);
        n_chk++;
        if (rr[0] !== 2'b10 || rr[1] !== 2'b10 || rl[0] !== 1'b0 || rl[1] !== 1'b1) begin
            n_fail++; $display("FAIL rsvd_rresp: got resp %b %b last %b %b required 10 10 / 0 1",
                               rr[0], rr[1], rl[0], rl[1]);
        end
        n_chk++;
        if (rd[0] !== 32'h5000 || rd[1] !== 32'h5001 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rsvd_data: got %h %h rvalid=%b required 5000 5001 0", rd[0], rd[1], rvalid);
        end
    endtask

    task automatic test_concurrent;
        logic [1:0] resp; logic [3:0] b_id;
        wd[0] = 32'h77; wd[1] = 32'h88; ws[0] = 4'hF; ws[1] = 4'hF;
        fork
            do_write(32'h300, 4'd1, 2'b01, 4'd9, 1, resp, b_id);
            do_read(32'h80, 4'd3, 2'b01, 4'd6);
        join
        n_chk++;
        if (resp !== 2'b00 || b_id !== 4'd9) begin
            n_fail++; $display("FAIL conc_b: got %b/%h required 00/9", resp, b_id);
        end
        n_chk++;
        if (rd[0] !== 32'd1 || rd[1] !== 32'd2 || rd[2] !== 32'd3 || rd[3] !== 32'd4 || rids !== 4'd6) begin
            n_fail++; $display("FAIL conc_r: got %h %h %h %h id=%h required 1 2 3 4 id 6",
                               rd[0], rd[1], rd[2], rd[3], rids);
        end
        do_read(32'h300, 4'd1, 2'b01, 4'd0);
        n_chk++;
        if (rd[0] !== 32'h77 || rd[1] !== 32'h88) begin
            n_fail++; $display("FAIL conc_mem: got %h %h required 77 88", rd[0], rd[1]);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        araddr = 32'h80; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 4'd2; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (rvalid !== 1'b1 || rdata !== 32'd2) begin
            n_fail++; $display("FAIL mid_beat2: got valid=%b data=%h required 1/2", rvalid, rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; rready = 1'b0;
        n_chk++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset: got rvalid=%b arready=%b required 0/1", rvalid, arready);
        end
        @(negedge clk);
        n_chk++;
        if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL mid_quiet: got rvalid=%b required 0", rvalid);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_single;
        test_incr_read;
        test_fixed_write;
        test_strobe;
        test_errors;
        test_concurrent;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3-style slave responder backed by an internal word-addressed SRAM array. It is the memory-side counterpart of the CPU's cache-to-AXI bridge, and is used as the bench and simulation memory behind that bridge. It serves FIXED and INCR bursts of up to 16 beats on independent read and write channels, with one outstanding transaction per channel.

Parameters:
- MEM_WORDS, 4096: depth of the 32-bit memory. Must be a power of 2.
- IDX_WIDTH, $clog2(MEM_WORDS): word index width. Word index = addr[IDX_WIDTH+1:2].
- RESP_SLVERR, 2'b10: response code for protocol errors.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- arid, input, 4: read ID.
- araddr, input, 32: read start address.
- arlen, input, 8: beats minus 1. Only [3:0] is used.
- arsize, input, 3: bytes per beat = 1<<arsize (0..2).
- arburst, input, 2: burst type. 00 = FIXED, 01 = INCR, 1x = reserved.
- arvalid, input, 1 / arready, output, 1: AR handshake.
- rid, output, 4: echo of the latched arid.
- rdata, output, 32: read data.
- rresp, output, 2: read response.
- rlast, output, 1: last read beat.
- rvalid, output, 1 / rready, input, 1: R handshake.
- awid, input, 4; awaddr, input, 32; awlen, input, 8; awsize, input, 3; awburst, input, 2: write address fields, same meaning as the AR fields.
- awvalid, input, 1 / awready, output, 1: AW handshake.
- wid, input, 4: write data ID. Ignored.
- wdata, input, 32: write data.
- wstrb, input, 4: byte enables.
- wlast, input, 1: last write beat.
- wvalid, input, 1 / wready, output, 1: W handshake.
- bid, output, 4: echo of the latched awid.
- bresp, output, 2: write response.
- bvalid, output, 1 / bready, input, 1: B handshake.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Outputs after reset: arready=1, awready=1. All of rvalid, rlast, wready, bvalid = 0. rid, bid, rresp, bresp = 0. rdata = 0.
- The memory contents are not cleared by reset.

- Read FSM states: R_IDLE, R_DATA.
- R_IDLE:
  - arready=1.
  - On arvalid&arready: latch id, len[3:0] into the beat counter, size, burst, and addr. Register rdata <= mem[araddr idx]. Go to R_DATA.
  - First rvalid appears the cycle after the AR handshake.
- R_DATA:
  - arready=0, rvalid=1, rlast = (counter==0).
  - rresp = RESP_SLVERR if the latched burst is reserved; otherwise 2'b00. Reserved bursts are addressed like INCR.
  - rvalid, rdata, rlast and rresp hold stable while rready=0.
  - On rvalid&rready with counter!=0: decrement the counter, advance the address, and load the next word into rdata so it is presented in the next cycle.
  - On rvalid&rready with rlast: return to R_IDLE. arready rises in the following cycle; there is no back-to-back AR in the same cycle.

- Address advance (shared by read and write):
  - INCR: addr += (1<<size), 32-bit add.
  - FIXED: addr is held.
  - The word index wraps modulo MEM_WORDS; there is no error on wrap.
  - Sub-word reads return the whole aligned word on rdata.

- Write FSM states: W_IDLE, W_DATA, W_RESP.
- W_IDLE:
  - awready=1.
  - On AW handshake: latch the fields and the counter. Clear an internal err flag, then set err if the burst is reserved. Go to W_DATA.
- W_DATA:
  - wready=1.
  - On each W beat: write mem[idx] byte-wise under wstrb, then advance the address.
  - Set err if wlast does not equal (counter==0) on that beat.
  - The beat where counter==0 ends the burst. The slave trusts its own counter, not wlast. Go to W_RESP.
- W_RESP:
  - bvalid=1, bresp = err ? RESP_SLVERR : 00.
  - On bready: return to W_IDLE.

- Read and write channels run fully concurrently.
- If a read and a write hit the same word in the same cycle, the read returns the pre-write data; the write is visible from the next cycle.
- Reset mid-burst aborts both FSMs to idle. No further beats are produced, and partially written words remain written.

Test Plan:
- Single read: write 0xDEADBEEF to word 0x10 via one AW/W beat (awsize=2, wstrb=F). B returns OKAY with bid=awid. Then read araddr=0x40, arlen=0. Required: one R beat with rdata=0xDEADBEEF, rlast=1, rresp=0, rid=arid.
- INCR burst read: preload words 0x20..0x23 = 1,2,3,4; araddr=0x80, arlen=3, arsize=2, burst=01, rready toggling 1/0. Required: beats 1,2,3,4 in order, each held while rready=0, rlast only on the 4th beat.
- FIXED burst write: awaddr=0x100, awlen=3, FIXED, wdata 0xA,0xB,0xC,0xD, wlast on beat 4. Required: word 0x40 = 0xD, words 0x41..0x43 unchanged, bresp=00.
- Strobes: word=0x11223344, write 0xAABBCCDD with wstrb=4'b0101. Required: read returns 0x11BB33DD.
- Errors: wlast asserted on beat 2 of a 4-beat write -> all 4 beats are still accepted, bresp=2'b10. arburst=2'b11, arlen=1 -> 2 beats, each with rresp=2'b10.
- Concurrency and reset: AR and AW handshake in the same cycle, both channels complete independently. Separately, assert reset during beat 2 of an 8-beat read -> next cycle rvalid=0, arready=1.
